// File: rtl/soc_led_sequencer.sv
// soc_led_sequencer: CPU-configured LED pattern sequencer acting as an Avalon-MM write master to a PIO s1 slave.
// Steps through up to 8 patterns with a programmable hold period, one-shot or looping.
module soc_led_sequencer #(
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);
    typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;
    state_t r_state, w_state_nxt;
    logic r_run, r_loop, r_irq_en, r_done;
    logic [PERIOD_W-1:0] r_period, r_cnt, w_cnt_nxt, w_load;
    logic [2:0] r_len, r_idx, w_idx_nxt;
    logic [7:0] r_pat [8];
    logic w_wr, w_ctrl_wr, w_start, w_finish, w_strobe, w_unused;
    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && address == 4'd0;
    assign w_start   = w_ctrl_wr && writedata[0];
    assign w_strobe  = r_state == STROBE;
    assign w_unused  = ^writedata;
    // HOLD spans load+1 cycles and STROBE one more, so the strobe spacing is max(PERIOD,2)
    assign w_load = (r_period < PERIOD_W'(2)) ? '0 : r_period - PERIOD_W'(2);
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_finish    = 1'b0;
        case (r_state)
            STROBE: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = w_load;
            end
            HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - PERIOD_W'(1);
                end else if (r_idx < r_len) begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = STROBE;
                end else if (r_loop) begin
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = STROBE;
                end else begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: ;
        endcase
        // A CTRL write overrides whatever the sequence would have done this cycle
        if (w_ctrl_wr) begin
            w_state_nxt = writedata[0] ? STROBE : IDLE;
            w_idx_nxt   = writedata[0] ? 3'd0 : r_idx;
            w_finish    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_loop   <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_period <= PERIOD_W'(DEFAULT_PERIOD);
            r_cnt    <= '0;
            r_len    <= 3'd0;
            r_idx    <= 3'd0;
            for (int i = 0; i < 8; i++) r_pat[i] <= 8'd0;
        end else begin
            r_idx <= w_idx_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_finish) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_ctrl_wr) begin
                r_run    <= writedata[0];
                r_loop   <= writedata[1];
                r_irq_en <= writedata[2];
            end
            if (w_start) r_done <= 1'b0;
            if (w_wr && address == 4'd1) r_period <= writedata[PERIOD_W-1:0];
            if (w_wr && address == 4'd2) r_len <= writedata[2:0];
            if (w_wr && address[3]) r_pat[address[2:0]] <= writedata[7:0];
        end
    end
    always_comb begin
        readdata = '0;
        if (address[3]) begin
            readdata = {24'b0, r_pat[address[2:0]]};
        end else begin
            case (address[2:0])
                3'd0:    readdata = {29'b0, r_irq_en, r_loop, r_run};
                3'd1:    readdata = 32'(r_period);
                3'd2:    readdata = {29'b0, r_len};
                3'd3:    readdata = {25'b0, r_idx, 2'b0, r_done, r_state != IDLE};
                default: readdata = '0;
            endcase
        end
    end
    assign irq            = r_done & r_irq_en;
    assign pio_address    = 2'b0;
    assign pio_chipselect = w_strobe;
    assign pio_write_n    = ~w_strobe;
    assign pio_writedata  = w_strobe ? {24'b0, r_pat[r_idx]} : 32'b0;
endmodule
